// File: rtl/pc_fetch_sequencer.sv
// Fetch/issue/memory sequencer for the PC/memory stage: owns the architectural PC and instruction register.
// Optional misaligned-branch trap enabled by defining PC_FETCH_SEQ_ALIGN_CHECK_EN.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] mout,
  input  logic        instr_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        e,
  output logic        s,
  output logic [31:0] next_pc,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        trap
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FETCH       = 3'd1,
    CAPTURE     = 3'd2,
    ISSUE       = 3'd3,
    MEM         = 3'd4,
    MEM_CAPTURE = 3'd5,
    UPDATE      = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        mem_we_reg;
  logic        branch_taken_reg;
  logic [31:0] branch_target_reg;
  logic [31:0] data_addr_reg, data_wr_reg;
  logic [31:0] load_data_reg;
  logic        load_valid_reg;
  logic        trap_reg, trap_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // e and s decode straight from the state register so an async reset drops them at once.
  always_comb begin
    state_next = state_reg;
    e          = 1'b0;
    s          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH:   state_next = CAPTURE;
      CAPTURE: state_next = ISSUE;
      ISSUE: begin
        if (instr_ready) state_next = mem_req ? MEM : UPDATE;
      end
      MEM: begin
        e          = 1'b1;
        s          = mem_we_reg;
        state_next = mem_we_reg ? UPDATE : MEM_CAPTURE;
      end
      MEM_CAPTURE: state_next = UPDATE;
      UPDATE:      state_next = run ? FETCH : IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    trap_next = 1'b0;
    if (branch_taken_reg) begin
      pc_next = {branch_target_reg[31:2], 2'b00};
    end else begin
      pc_next = pc_reg + PC_STEP;
    end
`ifdef PC_FETCH_SEQ_ALIGN_CHECK_EN
    if (branch_taken_reg && (branch_target_reg[1:0] != 2'b00)) begin
      pc_next   = TRAP_VECTOR;
      trap_next = 1'b1;
    end
`endif
  end

`ifndef PC_FETCH_SEQ_ALIGN_CHECK_EN
  // Target low bits and the trap vector only matter when the alignment check is built in.
  logic unused_align_bits;
  assign unused_align_bits = ^{TRAP_VECTOR, branch_target_reg[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg            <= RESET_PC;
      instr_reg         <= 32'd0;
      instr_valid_reg   <= 1'b0;
      mem_we_reg        <= 1'b0;
      branch_taken_reg  <= 1'b0;
      branch_target_reg <= 32'd0;
      data_addr_reg     <= 32'd0;
      data_wr_reg       <= 32'd0;
      load_data_reg     <= 32'd0;
      load_valid_reg    <= 1'b0;
      trap_reg          <= 1'b0;
    end else begin
      load_valid_reg <= 1'b0;
      trap_reg       <= 1'b0;
      case (state_reg)
        CAPTURE: begin
          instr_reg       <= mout;
          instr_valid_reg <= 1'b1;
        end
        ISSUE: begin
          // Side-band inputs are only meaningful in the handshake cycle.
          if (instr_ready) begin
            instr_valid_reg   <= 1'b0;
            mem_we_reg        <= mem_we;
            branch_taken_reg  <= branch_taken;
            branch_target_reg <= branch_target;
            if (mem_req) begin
              data_addr_reg <= mem_addr;
              data_wr_reg   <= mem_wdata;
            end
          end
        end
        MEM_CAPTURE: begin
          load_data_reg  <= mout;
          load_valid_reg <= 1'b1;
        end
        UPDATE: begin
          pc_reg   <= pc_next;
          trap_reg <= trap_next;
        end
        default: ;
      endcase
    end
  end

  assign next_pc     = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign data_addr   = data_addr_reg;
  assign data_wr     = data_wr_reg;
  assign load_data   = load_data_reg;
  assign load_valid  = load_valid_reg;
  assign trap        = trap_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: memory-stage model plus an instruction-level reference model,
// directed cases then randomized instructions, one line printed per instruction.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] mout;
  logic        instr_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        e;
  logic        s;
  logic [31:0] next_pc;
  logic [31:0] data_addr;
  logic [31:0] data_wr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] load_data;
  logic        load_valid;
  logic        trap;

  int checks   = 0;
  int failures = 0;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .mout          (mout),
    .instr_ready   (instr_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .e             (e),
    .s             (s),
    .next_pc       (next_pc),
    .data_addr     (data_addr),
    .data_wr       (data_wr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .trap          (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'hAC85_0022;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // PC/memory stage: one-cycle registered read, store on s.
  logic [31:0] env_mem     [256];
  bit          env_written [256];

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    int i;
    i = widx(a);
    return env_written[i] ? env_mem[i] : init_word(i);
  endfunction

  always @(posedge clk) begin
    if (e) begin
      mout <= env_rd(data_addr);
      if (s) begin
        env_mem[widx(data_addr)]     <= data_wr;
        env_written[widx(data_addr)] <= 1'b1;
      end
    end else begin
      mout <= env_rd(next_pc);
    end
  end

  // Reference model state: architectural PC and memory contents.
  logic [31:0] ref_mem [256];
  logic [31:0] model_pc;
  int          lat_next;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_issue(input int exp_lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (instr_valid) seen = 1'b1;
    end
    check_value("issue_latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic do_instr(input int hold, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic br, input logic [31:0] tgt, input bit drop_run);
    logic [31:0] exp_instr, exp_load, new_pc;
    logic        exp_trap;
    int          len;
    wait_issue(lat_next);
    exp_instr = ref_mem[widx(model_pc)];
    check_value("instr", instr, exp_instr);
    check_value("pc_issue", next_pc, model_pc);
    check_value("e_issue", 32'(e), 32'd0);
    check_value("s_issue", 32'(s), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_value("instr_hold", instr, exp_instr);
      check_value("valid_hold", 32'(instr_valid), 32'd1);
      check_value("pc_hold", next_pc, model_pc);
      check_value("e_hold", 32'(e), 32'd0);
    end
    instr_ready   = 1'b1;
    mem_req       = req;
    mem_we        = we;
    mem_addr      = addr;
    mem_wdata     = wdata;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
    instr_ready   = 1'b0;
    mem_req       = 1'($urandom);
    mem_we        = 1'($urandom);
    mem_addr      = $urandom;
    mem_wdata     = $urandom;
    branch_taken  = 1'($urandom);
    branch_target = $urandom;
    if (drop_run) run = 1'b0;
    check_value("valid_clear", 32'(instr_valid), 32'd0);

    len      = !req ? 1 : (we ? 2 : 3);
    exp_load = ref_mem[widx(addr)];
    if (req && we) ref_mem[widx(addr)] = wdata;
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check_value("e_exec", 32'(e), 32'(req && k == 0));
      check_value("s_exec", 32'(s), 32'(req && we && k == 0));
      if (req && k == 0) check_value("data_addr", data_addr, addr);
      if (req && we && k == 0) check_value("data_wr", data_wr, wdata);
      check_value("load_valid", 32'(load_valid), 32'(req && !we && k == 2));
      if (req && !we && k == 2) check_value("load_data", load_data, exp_load);
      check_value("trap_exec", 32'(trap), 32'd0);
    end

    exp_trap = 1'b0;
    if (!br) begin
      new_pc = model_pc + 32'd4;
    end else begin
`ifdef PC_FETCH_SEQ_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        new_pc   = TRAP_VEC;
        exp_trap = 1'b1;
      end else begin
        new_pc = tgt & 32'hFFFF_FFFC;
      end
`else
      new_pc = tgt & 32'hFFFF_FFFC;
`endif
    end
    @(posedge clk);
    #1;
    check_value("pc_update", next_pc, new_pc);
    check_value("trap", 32'(trap), 32'(exp_trap));
    check_value("e_after", 32'(e), 32'd0);
    model_pc = new_pc;
    if (drop_run) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk);
        #1;
        check_value("idle_valid", 32'(instr_valid), 32'd0);
        check_value("idle_pc", next_pc, model_pc);
        check_value("idle_e", 32'(e), 32'd0);
      end
      run      = 1'b1;
      lat_next = 3;
    end else begin
      lat_next = 2;
    end
    $display("instr %h req=%0d we=%0d addr=%h br=%0d tgt=%h -> pc=%h trap=%0d",
             exp_instr, req, we, addr, br, tgt, model_pc, exp_trap);
  endtask

  initial begin
    logic [31:0] a, w, t;
    int          r;
    rst_n         = 1'b0;
    run           = 1'b0;
    instr_ready   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    repeat (2) @(posedge clk);
    #1;
    check_value("rst_pc", next_pc, RST_PC);
    check_value("rst_e", 32'(e), 32'd0);
    check_value("rst_s", 32'(s), 32'd0);
    check_value("rst_instr", instr, 32'd0);
    check_value("rst_valid", 32'(instr_valid), 32'd0);
    check_value("rst_load_data", load_data, 32'd0);
    check_value("rst_load_valid", 32'(load_valid), 32'd0);
    check_value("rst_trap", 32'(trap), 32'd0);
    check_value("rst_data_addr", data_addr, 32'd0);
    check_value("rst_data_wr", data_wr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("idle_no_run_pc", next_pc, RST_PC);
    check_value("idle_no_run_valid", 32'(instr_valid), 32'd0);
    run      = 1'b1;
    model_pc = RST_PC;
    lat_next = 3;

    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0, 1'b0);
    check_value("load_deadbeef", load_data, 32'hDEAD_BEEF);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0042, 1'b0);
    do_instr(5, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_instr(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    do_instr(0, 1'b1, 1'b1, 32'h0000_0208, 32'h1234_5678, 1'b0, 32'h0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 3));
      a = 32'h200 + {22'd0, 4'($urandom_range(0, 15)), 2'b00};
      w = $urandom;
      t = 32'($urandom_range(0, 255));
      do_instr(int'($urandom_range(0, 3)), r < 2, r == 0, a, w,
               $urandom_range(0, 9) < 3, t, $urandom_range(0, 9) == 0);
    end

    // Async reset in the middle of a store: the write must not happen.
    wait_issue(lat_next);
    check_value("instr_pre_rst", instr, ref_mem[widx(model_pc)]);
    instr_ready   = 1'b1;
    mem_req       = 1'b1;
    mem_we        = 1'b1;
    mem_addr      = 32'h0000_0204;
    mem_wdata     = ~ref_mem[widx(32'h204)];
    branch_taken  = 1'b0;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    mem_req     = 1'b0;
    check_value("e_store_mem", 32'(e), 32'd1);
    check_value("s_store_mem", 32'(s), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_e", 32'(e), 32'd0);
    check_value("arst_s", 32'(s), 32'd0);
    check_value("arst_pc", next_pc, RST_PC);
    check_value("arst_valid", 32'(instr_valid), 32'd0);
    check_value("arst_data_addr", data_addr, 32'd0);
    @(posedge clk);
    #1;
    check_value("arst_s_edge", 32'(s), 32'd0);
    $display("async reset during store at addr 00000204");
    rst_n    = 1'b1;
    model_pc = RST_PC;
    lat_next = 3;
    do_instr(0, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sits directly upstream of the PC/memory stage and drives its E, S, Next_PC, data_addr_in and data_in inputs.
- Consumes that stage's registered Mout, which has one-cycle read latency.
- Runs a fetch/issue/memory FSM, holds the architectural PC, and latches fetched instructions into an instruction register.
- Hands each instruction downstream with a valid/ready handshake; computes PC+4 or the branch target after each instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned branch; used only with ALIGN_CHECK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; allows leaving IDLE.
- mout  in  32  registered memory output from the PC/memory stage.
- instr_ready  in  1  downstream accepts instr.
- mem_req  in  1  sampled with handshake: instruction needs a data access.
- mem_we  in  1  sampled with handshake: data access is a store.
- mem_addr  in  32  sampled with handshake: data byte address.
- mem_wdata  in  32  sampled with handshake: store data.
- branch_taken  in  1  sampled with handshake.
- branch_target  in  32  sampled with handshake.
- e  out  1  to PC/memory stage: 1 = execute, 0 = fetch.
- s  out  1  to PC/memory stage: store strobe.
- next_pc  out  32  to PC/memory stage; always equals the pc register.
- data_addr  out  32  to PC/memory stage.
- data_wr  out  32  to PC/memory stage.
- instr  out  32  instruction register.
- instr_valid  out  1  instr holds an unaccepted instruction.
- load_data  out  32  captured load result.
- load_valid  out  1  one-cycle pulse when load_data updates.
- trap  out  1  one-cycle pulse on misaligned branch; constant 0 without ALIGN_CHECK_EN.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, pc=RESET_PC.
  - instr, load_data, data_addr, data_wr all zero.
  - e, s, instr_valid, load_valid, trap all 0.
- Deasserting reset takes effect at the next clk edge.
- Reset mid-operation aborts any access: no s pulse may follow rst_n low.
- Encoding: IDLE=0, FETCH=1, CAPTURE=2, ISSUE=3, MEM=4, MEM_CAPTURE=5, UPDATE=6.
- IDLE:
  - e=0, s=0.
  - Go to FETCH when run=1.
- FETCH (1 cycle):
  - e=0, next_pc=pc; memory reads word pc[31:2].
  - Always go to CAPTURE.
- CAPTURE (1 cycle):
  - mout is valid; at cycle end instr<=mout and instr_valid<=1.
  - Go to ISSUE.
- ISSUE:
  - Hold instr and instr_valid=1 until instr_ready=1.
  - On handshake, sample mem_req, mem_we, mem_addr, mem_wdata, branch_taken, branch_target into registers; clear instr_valid.
  - mem_req=1 goes to MEM; otherwise goes to UPDATE.
  - Inputs outside the handshake cycle are ignored.
- MEM (1 cycle):
  - e=1, s=mem_we (registered), data_addr=mem_addr, data_wr=mem_wdata.
  - s is high for exactly this one cycle.
  - Store: go to UPDATE. Load: go to MEM_CAPTURE.
- MEM_CAPTURE (1 cycle):
  - load_data<=mout; load_valid pulses 1 cycle.
  - Go to UPDATE.
- UPDATE (1 cycle):
  - pc <= branch_taken ? {branch_target[31:2],2'b00} : pc+PC_STEP, modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
  - Go to FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the current instruction completes through UPDATE, then the FSM goes to IDLE.
- Latency, fetch to instr_valid: 2 cycles.
- Minimum instruction period with zero-wait instr_ready:
  - 4 cycles with no access.
  - 5 cycles for a store.
  - 6 cycles for a load.
- e=0 in every state except MEM. s=0 in every state except a store MEM.

Optional Feature:
- Macro: PC_FETCH_SEQ_ALIGN_CHECK_EN.
- Defined: in UPDATE, if branch_taken=1 and branch_target[1:0]!=0, then pc<=TRAP_VECTOR and trap pulses 1 cycle.
- Not defined: the low two bits are cleared silently, the TRAP_VECTOR parameter is unused, and trap is tied to 0.

Test Plan:
- Reset then run=1, instr_ready=1, no mem/branch, memory word0=32'hAC850022 -> next_pc 0 then 4, instr=32'hAC850022 two cycles after FETCH, e=0 and s=0 throughout.
- Handshake with mem_req=1, mem_we=1, mem_addr=32'h0000_0010, mem_wdata=32'hDEAD_BEEF -> one cycle e=1, s=1, data_addr=0x10; a later load from 0x10 returns load_data=32'hDEAD_BEEF with load_valid one cycle.
- Handshake with branch_taken=1, branch_target=32'h0000_0040 -> next fetch at next_pc=0x40; target 0x42 -> pc=0x40 (no macro) or pc=0x100 with trap pulse (macro).
- Hold instr_ready=0 for 5 cycles in ISSUE -> instr and instr_valid stable, e=0, pc unchanged; accepted on the first cycle instr_ready=1.
- pc=32'hFFFF_FFFC, no branch -> next pc=0; run=0 during MEM -> completes UPDATE then IDLE.
- Assert rst_n=0 asynchronously during a store MEM cycle -> s and e drop immediately, pc=RESET_PC, state=IDLE.
